// File: rtl/cmd_frame_tx.sv
// cmd_frame_tx: host-side command framer. Accepts one command over a
// valid/ready handshake, expands it into the controller byte protocol
// (header byte plus fields) and sends each byte as a UART frame on TX_OUT.
// Optional feature: define CMD_TX_PARITY_EN to add the parity bit
// (parity_enable / parity_type); otherwise frames are start + 8 data + stop.
module cmd_frame_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_type,
  input  logic [RF_ADDR-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data_a,
  input  logic [DATA_WIDTH-1:0] cmd_data_b,
  input  logic [3:0]            cmd_fun,
  input  logic [DIV_WIDTH-1:0]  bit_div,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  cmd_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef CMD_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                       state_q, state_d;
  logic [DIV_WIDTH-1:0]         cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]         div_q, div_d;
  logic [IDX_W-1:0]             bit_idx_q, bit_idx_d;
  logic [1:0]                   byte_idx_q, byte_idx_d;
  logic [1:0]                   last_byte_q, last_byte_d;
  logic [3:0][DATA_WIDTH-1:0]   frame_q, frame_d;
  logic                         tx_q, tx_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic [DATA_WIDTH-1:0]        cur_byte;
  logic [IDX_W-1:0]             nxt_idx;
  logic                         bit_end;

`ifdef CMD_TX_PARITY_EN
  logic                         par_en_q, par_en_d;
  logic                         par_odd_q, par_odd_d;
`else
  logic                         unused_parity;
  assign unused_parity = ^{parity_enable, parity_type};
`endif

  assign cur_byte  = frame_q[byte_idx_q];
  assign nxt_idx   = bit_idx_q + IDX_W'(1);
  assign bit_end   = (cnt_q == div_q - DIV_WIDTH'(1));

  assign TX_OUT    = tx_q;
  assign busy      = busy_q;
  assign cmd_ready = ~busy_q;
  assign cmd_done  = done_q;

  // Next-state logic: bit timing, frame sequencing and command latching
  always_comb begin
    state_d     = state_q;
    cnt_d       = bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    last_byte_d = last_byte_q;
    frame_d     = frame_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef CMD_TX_PARITY_EN
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          // Latch everything the command needs; later input changes are ignored.
          frame_d = '0;
          case (cmd_type)
            2'd0: begin
              frame_d[0]  = DATA_WIDTH'(8'hAA);
              frame_d[1]  = DATA_WIDTH'(cmd_addr);
              frame_d[2]  = cmd_data_a;
              last_byte_d = 2'd2;
            end
            2'd1: begin
              frame_d[0]  = DATA_WIDTH'(8'hBB);
              frame_d[1]  = DATA_WIDTH'(cmd_addr);
              last_byte_d = 2'd1;
            end
            2'd2: begin
              frame_d[0]  = DATA_WIDTH'(8'hCC);
              frame_d[1]  = cmd_data_a;
              frame_d[2]  = cmd_data_b;
              frame_d[3]  = DATA_WIDTH'(cmd_fun);
              last_byte_d = 2'd3;
            end
            default: begin
              frame_d[0]  = DATA_WIDTH'(8'hDD);
              frame_d[1]  = DATA_WIDTH'(cmd_fun);
              last_byte_d = 2'd1;
            end
          endcase
          div_d      = (bit_div == '0) ? DIV_WIDTH'(1) : bit_div;
`ifdef CMD_TX_PARITY_EN
          par_en_d   = parity_enable;
          par_odd_d  = parity_type;
`endif
          byte_idx_d = 2'd0;
          state_d    = START;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef CMD_TX_PARITY_EN
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = (^cur_byte) ^ par_odd_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = nxt_idx;
            tx_d      = cur_byte[nxt_idx];
          end
        end
      end
`ifdef CMD_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (byte_idx_q == last_byte_q) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
            tx_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset parks the line high and drops the command
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= DIV_WIDTH'(1);
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      last_byte_q <= '0;
      frame_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CMD_TX_PARITY_EN
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      last_byte_q <= last_byte_d;
      frame_q     <= frame_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef CMD_TX_PARITY_EN
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Bench for cmd_frame_tx: directed commands plus randomized commands, each
// checked cycle by cycle against a bit-stream model built from the byte protocol.
module tb_cmd_frame_tx;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_data_a;
  logic [7:0]  cmd_data_b;
  logic [3:0]  cmd_fun;
  logic [15:0] bit_div;
  logic        parity_enable;
  logic        parity_type;
  logic        TX_OUT;
  logic        busy;
  logic        cmd_done;

  int n_cmp = 0;
  int n_err = 0;

  logic exp_q[$];
  int   exp_div;

  cmd_frame_tx #(.DATA_WIDTH(8), .RF_ADDR(4), .DIV_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data_a(cmd_data_a),
    .cmd_data_b(cmd_data_b), .cmd_fun(cmd_fun), .bit_div(bit_div),
    .parity_enable(parity_enable), .parity_type(parity_type),
    .TX_OUT(TX_OUT), .busy(busy), .cmd_done(cmd_done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: command -> byte list -> per-bit line levels
  task automatic model_build(input logic [1:0] t, input logic [3:0] addr,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] fun, input logic [15:0] div,
                             input logic pen, input logic ptyp);
    logic [7:0] bytes[$];
    logic       par_on;
    case (t)
      2'd0:    bytes = '{8'hAA, {4'h0, addr}, a};
      2'd1:    bytes = '{8'hBB, {4'h0, addr}};
      2'd2:    bytes = '{8'hCC, a, b, {4'h0, fun}};
      default: bytes = '{8'hDD, {4'h0, fun}};
    endcase
`ifdef CMD_TX_PARITY_EN
    par_on = pen;
`else
    par_on = 1'b0;
`endif
    exp_q.delete();
    foreach (bytes[k]) begin
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(bytes[k][i]);
      if (par_on) exp_q.push_back((^bytes[k]) ^ ptyp);
      exp_q.push_back(1'b1);
    end
    exp_div = (div == 16'd0) ? 1 : int'(div);
  endtask

  // Present a command (called at a falling edge) and wait for ready
  task automatic issue(input logic [1:0] t, input logic [3:0] addr,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] fun, input logic [15:0] div,
                       input logic pen, input logic ptyp);
    int w;
    cmd_type = t; cmd_addr = addr; cmd_data_a = a; cmd_data_b = b;
    cmd_fun = fun; bit_div = div; parity_enable = pen; parity_type = ptyp;
    cmd_valid = 1'b1;
    model_build(t, addr, a, b, fun, div, pen, ptyp);
    $display("cmd type=%0d addr=%0h a=%0h b=%0h fun=%0h div=%0d par=%0d/%0d bits=%0d",
             t, addr, a, b, fun, div, pen, ptyp, exp_q.size());
    w = 0;
    while (!cmd_ready && w < 2000) begin
      @(negedge CLK);
      w++;
    end
    check("ready_at_accept", cmd_ready, 1'b1);
  endtask

  // Follow the accepted command cycle by cycle; ends on the cmd_done cycle
  task automatic expect_cmd(input bit pulse_valid);
    int total;
    @(negedge CLK);
    total = exp_q.size() * exp_div;
    for (int i = 0; i < total; i++) begin
      check($sformatf("tx[%0d]", i), TX_OUT, exp_q[i / exp_div]);
      check("busy", busy, 1'b1);
      check("ready_busy", cmd_ready, 1'b0);
      check("done_early", cmd_done, 1'b0);
      cmd_type = 2'($urandom); cmd_addr = 4'($urandom);
      cmd_data_a = 8'($urandom); cmd_data_b = 8'($urandom);
      cmd_fun = 4'($urandom); bit_div = 16'($urandom_range(0, 5));
      parity_enable = 1'($urandom); parity_type = 1'($urandom);
      cmd_valid = (pulse_valid && i < total - 1) ? 1'($urandom) : 1'b0;
      @(negedge CLK);
    end
    check("done_pulse", cmd_done, 1'b1);
    check("busy_end", busy, 1'b0);
    check("ready_end", cmd_ready, 1'b1);
    check("tx_gap", TX_OUT, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("idle_tx", TX_OUT, 1'b1);
      check("idle_done", cmd_done, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_ready", cmd_ready, 1'b1);
    end
  endtask

  initial begin
    RST = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_addr = '0;
    cmd_data_a = '0; cmd_data_b = '0; cmd_fun = '0; bit_div = 16'd1;
    parity_enable = 1'b0; parity_type = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", cmd_done, 1'b0);
    RST = 1'b0;
    idle_cycles(50);

    // RF write, bit_div 4, no parity: done at accept+121
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 16'd4, 1'b0, 1'b0);
    expect_cmd(1'b0);
    idle_cycles(3);

    // ALU op with operands, even parity, bit_div 1
    issue(2'd2, 4'h0, 8'h12, 8'h34, 4'h1, 16'd1, 1'b1, 1'b0);
    expect_cmd(1'b0);
    idle_cycles(3);

    // ALU op without operands, odd parity, bit_div 0 treated as 1
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h7, 16'd0, 1'b1, 1'b1);
    expect_cmd(1'b0);
    idle_cycles(3);

    // Back-to-back: second command accepted on the cmd_done cycle
    issue(2'd1, 4'h9, 8'h00, 8'h00, 4'h0, 16'd2, 1'b0, 1'b0);
    expect_cmd(1'b1);
    issue(2'd0, 4'hA, 8'hE7, 8'h00, 4'h0, 16'd3, 1'b1, 1'b1);
    expect_cmd(1'b1);
    idle_cycles(3);

    // Mid-frame reset during byte 2 data bits
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 16'd2, 1'b0, 1'b0);
    @(negedge CLK);
    repeat (24) @(negedge CLK);
    check("pre_rst_tx", TX_OUT, 1'b0);
    RST = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check("rst_async_tx", TX_OUT, 1'b1);
    check("rst_async_busy", busy, 1'b0);
    repeat (3) @(negedge CLK);
    check("rst_hold_done", cmd_done, 1'b0);
    RST = 1'b0;
    idle_cycles(60);
    issue(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 16'd3, 1'b0, 1'b0);
    expect_cmd(1'b0);
    idle_cycles(2);

    // Randomized commands, sometimes chained
    for (int n = 0; n < 30; n++) begin
      issue(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
            16'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      expect_cmd(1'b1);
      if ($urandom_range(0, 1) == 0) idle_cycles(int'($urandom_range(1, 4)));
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_frame_tx.md
# cmd_frame_tx

Host-side command framer that sits directly upstream of the system's UART receive input. It accepts one complete command (register write, register read, ALU op with operands, ALU op without operands) over a valid/ready handshake. It expands the command into the system controller's byte protocol and serializes each byte as a UART frame on a single line that drives `UART_RX_IN`. Benches use it as the stimulus driver; it is also the host-side transmitter in FPGA bring-up.

## Interface
- `DATA_WIDTH`, 8: byte width of every frame payload.
- `RF_ADDR`, 4: register-file address width; zero-extended to `DATA_WIDTH` on the line.
- `DIV_WIDTH`, 16: width of the bit-period divisor.

- `CLK` in 1: transmit clock. All logic is on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block idle and able to accept a command.
- `cmd_type` in 2: 0=RF write, 1=RF read, 2=ALU with operands, 3=ALU without operands.
- `cmd_addr` in `RF_ADDR`: RF address, used by types 0 and 1.
- `cmd_data_a` in `DATA_WIDTH`: write data for type 0, operand A for type 2.
- `cmd_data_b` in `DATA_WIDTH`: operand B for type 2.
- `cmd_fun` in 4: ALU function, used by types 2 and 3; zero-extended on the line.
- `bit_div` in `DIV_WIDTH`: `CLK` cycles per UART bit. A value of 0 is treated as 1.
- `parity_enable` in 1: insert parity bit (`CMD_TX_PARITY_EN` builds only).
- `parity_type` in 1: 0=even, 1=odd.
- `TX_OUT` out 1: serial line, idle high.
- `busy` out 1: high from accept through the end of the last stop bit.
- `cmd_done` out 1: one-cycle pulse after the last stop bit of a command.

## Operation
- Handshake: a command is accepted on the cycle where `cmd_valid && cmd_ready`.
  - All command fields, `bit_div`, `parity_enable` and `parity_type` are latched on that cycle.
  - Input changes after accept have no effect until the next accept.
- Byte sequences, sent in the order listed:
  - Type 0: 0xAA, addr, data_a (3 bytes).
  - Type 1: 0xBB, addr (2 bytes).
  - Type 2: 0xCC, data_a, data_b, fun (4 bytes).
  - Type 3: 0xDD, fun (2 bytes).
- Frame format: start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1).
- Parity is computed as follows:
  - Even: parity bit = XOR of the data bits.
  - Odd: the inverse of that XOR.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on accept.
  - START→DATA after one bit period.
  - DATA→PARITY after 8 bits if parity is enabled, otherwise DATA→STOP.
  - PARITY→STOP after one bit period.
  - STOP→START if more bytes remain in the command.
  - STOP→IDLE after the last byte.
- Counters:
  - The bit-period counter counts 0..`bit_div`−1.
  - A 3-bit data-bit index.
  - A 2-bit byte index compared against the per-type byte count (latched at accept).
- Back-to-back frames within one command have no idle gap.

## Timing
- Reset values: `TX_OUT`=1, `cmd_ready`=1, `busy`=0, `cmd_done`=0. The FSM returns to IDLE and all counters clear.
- `RST` asserted mid-frame forces `TX_OUT` high immediately (asynchronously) and abandons the command. No `cmd_done` is produced.
- Accept at cycle N:
  - `cmd_ready` drops and `busy` rises at N+1.
  - `TX_OUT` goes low at N+1.
- Each bit is held exactly `max(bit_div,1)` cycles.
- Frame length F = 10 bit periods, or 11 with parity.
- For a command of B bytes, the last stop bit ends at cycle N+B·F·D, where D = effective `bit_div`.
  - `cmd_done` pulses for one cycle at N+B·F·D+1.
  - At that cycle `busy`=0 and `cmd_ready`=1.
- A new accept is possible on the same cycle `cmd_done` pulses. The next start bit then follows with no extra gap beyond that one idle-high cycle.
- `cmd_valid` while busy is ignored. It is not queued.

## Configuration
- `CMD_TX_PARITY_EN`:
  - Defined: the PARITY state exists, and `parity_enable`/`parity_type` are honoured as above.
  - Undefined: the PARITY state and parity logic are removed, `parity_enable`/`parity_type` are ignored, and F is always 10.

## Test plan
- Reset then idle: `TX_OUT`=1, `cmd_ready`=1, `busy`=0 for 50 cycles with no command.
- RF write, `bit_div`=4, no parity, type 0, addr 0x5, data_a 0x3C:
  - Line carries bytes 0xAA, 0x05, 0x3C LSB-first, each bit 4 cycles wide.
  - `cmd_done` pulses at accept+121.
- ALU op, `bit_div`=1, even parity, type 2, A=0x12, B=0x34, fun=0x1:
  - Bytes are 0xCC, 0x12, 0x34, 0x01 with parity bits 0, 0, 1, 1.
  - Each frame is 11 cycles; `cmd_done` pulses at accept+45.
- Odd parity and `bit_div`=0: type 3, fun=0x7.
  - Bytes 0xDD (parity 1) and 0x07 (parity 0), each bit 1 cycle wide.
- Handshake: hold `cmd_valid` high across two commands.
  - The second is accepted on the `cmd_done` cycle, with exactly one idle-high cycle between commands.
  - `cmd_valid` pulses mid-command are ignored.
- Mid-frame reset: assert `RST` during the DATA state of byte 2 of a type 0 command.
  - `TX_OUT` goes to 1 immediately and no `cmd_done` is produced.
  - After release, a type 1 command (addr 0x2) sends 0xBB, 0x02 correctly.
